// File: rtl/receiver.sv
// UART-style serial receiver: 8N1 frames, CLKS_PER_BIT clocks per bit, one-byte output buffer
// with ack handshake, frame-error and overrun pulses.
module receiver #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [0:7] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] HalfCnt = 8'(HALF);
  localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);
  localparam bit NoHalf = (HALF == 0);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e     state;
  logic       sync1;
  logic       srx;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [0:7] shift;

  always_comb begin
    rx_busy = (state != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      srx       <= 1'b1;
      state     <= StIdle;
      cnt       <= 8'd0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1     <= RXD;
      srx       <= sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumer ack; a completing frame below may re-assert rx_valid on the same edge.
      if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (!srx) begin
            idx <= 3'd0;
            if (NoHalf) begin
              state <= StData;
              cnt   <= 8'd0;
            end else begin
              state <= StStart;
              cnt   <= 8'd1;
            end
          end
        end
        StStart: begin
          if (cnt == HalfCnt) begin
            cnt <= 8'd0;
            idx <= 3'd0;
            state <= srx ? StIdle : StData;  // start bit gone by mid-bit: treat as a glitch
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StData: begin
          if (cnt == LastCnt) begin
            shift[idx] <= srx;
            cnt        <= 8'd0;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= StStop;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StStop: begin
          if (cnt == LastCnt) begin
            cnt   <= 8'd0;
            state <= StIdle;
            if (!srx) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || rx_ack) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: one instance at 1 clock/bit, one at 16 clocks/bit.
module tb_receiver;

  logic       clk;
  logic       reset;
  logic       rxd_a, rxd_b;
  logic       rx_ack_a, rx_ack_b;
  logic [0:7] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       rx_busy_a, rx_busy_b;
  logic       frame_err_a, frame_err_b;
  logic       overrun_a, overrun_b;

  int tests = 0;
  int fails = 0;
  int fe_a_cnt = 0;
  int ov_a_cnt = 0;
  int fe_b_cnt = 0;
  int busy_b_cnt = 0;

  receiver #(.CLKS_PER_BIT(1)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .RXD      (rxd_a),
    .rx_data  (rx_data_a),
    .rx_valid (rx_valid_a),
    .rx_ack   (rx_ack_a),
    .rx_busy  (rx_busy_a),
    .frame_err(frame_err_a),
    .overrun  (overrun_a)
  );

  receiver #(.CLKS_PER_BIT(16)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .RXD      (rxd_b),
    .rx_data  (rx_data_b),
    .rx_valid (rx_valid_b),
    .rx_ack   (rx_ack_b),
    .rx_busy  (rx_busy_b),
    .frame_err(frame_err_b),
    .overrun  (overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse-width counters: each pulse cycle is counted, so a 1-cycle pulse adds exactly 1.
  always @(negedge clk) begin
    if (frame_err_a) fe_a_cnt++;
    if (overrun_a)   ov_a_cnt++;
    if (frame_err_b) fe_b_cnt++;
    if (rx_busy_b)   busy_b_cnt++;
  end

  task automatic send_bit(input bit sel, input logic v, input int cycles);
    @(posedge clk);
    #1;
    if (sel) rxd_b = v;
    else     rxd_a = v;
    repeat (cycles - 1) @(posedge clk);
  endtask

  // rx_data[0] is the first bit on the wire, i.e. val[7] in numeric order.
  task automatic send_frame(input bit sel, input logic [7:0] val, input logic stop, input int cpb);
    send_bit(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(sel, val[7-i], cpb);
    send_bit(sel, stop, cpb);
  endtask

  task automatic ack_a();
    @(posedge clk);
    #1 rx_ack_a = 1'b1;
    @(posedge clk);
    #1 rx_ack_a = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (rx_data_a !== 8'h00 || rx_valid_a !== 1'b0 || rx_busy_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: data=%h valid=%b busy=%b, want 00/0/0", rx_data_a, rx_valid_a,
               rx_busy_a);
    end
    tests++;
    if (frame_err_a !== 1'b0 || overrun_a !== 1'b0 || rx_valid_b !== 1'b0 ||
        rx_data_b !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: fe=%b ov=%b valid_b=%b data_b=%h, want 0/0/0/00",
               frame_err_a, overrun_a, rx_valid_b, rx_data_b);
    end
    #3 reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_busy_a !== 1'b0 || rx_valid_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0/0", rx_busy_a, rx_valid_a);
    end
  endtask

  task automatic test_latency();
    fork
      begin
        send_frame(1'b0, 8'hA5, 1'b1, 1);
        send_bit(1'b0, 1'b1, 4);
      end
      begin
        @(posedge clk);  // edge after which RXD falls
        repeat (11) @(posedge clk);
        @(negedge clk);
        tests++;
        if (rx_valid_a !== 1'b0) begin
          fails++;
          $display("FAIL latency_early: valid=%b after edge 11, want 0", rx_valid_a);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (rx_valid_a !== 1'b1 || rx_data_a !== 8'hA5 || frame_err_a !== 1'b0) begin
          fails++;
          $display("FAIL latency_a5: valid=%b data=%h fe=%b, want 1/a5/0", rx_valid_a,
                   rx_data_a, frame_err_a);
        end
      end
    join
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_a_cnt;
    ack_a();
    @(negedge clk);
    tests++;
    if (rx_valid_a !== 1'b0 || rx_data_a !== 8'hA5) begin
      fails++;
      $display("FAIL ack_clear: valid=%b data=%h, want 0/a5", rx_valid_a, rx_data_a);
    end
    fork
      begin
        send_frame(1'b0, 8'h3C, 1'b1, 1);
        send_frame(1'b0, 8'hC3, 1'b1, 1);
        send_bit(1'b0, 1'b1, 6);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (rx_valid_a) break;
        end
        tests++;
        if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h3C) begin
          fails++;
          $display("FAIL b2b_first: valid=%b data=%h, want 1/3c", rx_valid_a, rx_data_a);
        end
        ack_a();
      end
    join
    @(negedge clk);
    tests++;
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'hC3 || ov_a_cnt != ov0) begin
      fails++;
      $display("FAIL b2b_second: valid=%b data=%h overruns=%0d, want 1/c3/0", rx_valid_a,
               rx_data_a, ov_a_cnt - ov0);
    end
  endtask

  task automatic test_overrun();
    int ov0;
    ack_a();
    ov0 = ov_a_cnt;
    send_frame(1'b0, 8'h5A, 1'b1, 1);
    send_frame(1'b0, 8'h96, 1'b1, 1);
    send_bit(1'b0, 1'b1, 6);
    @(negedge clk);
    tests++;
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h5A) begin
      fails++;
      $display("FAIL overrun_keep: valid=%b data=%h, want 1/5a", rx_valid_a, rx_data_a);
    end
    tests++;
    if (ov_a_cnt - ov0 != 1) begin
      fails++;
      $display("FAIL overrun_pulse: cycles high=%0d, want 1", ov_a_cnt - ov0);
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_a_cnt;
    send_frame(1'b0, 8'hFF, 1'b0, 1);
    send_bit(1'b0, 1'b1, 6);
    @(negedge clk);
    tests++;
    if (fe_a_cnt - fe0 != 1 || rx_valid_a !== 1'b1 || rx_data_a !== 8'h5A) begin
      fails++;
      $display("FAIL frame_err: pulses=%0d valid=%b data=%h, want 1/1/5a", fe_a_cnt - fe0,
               rx_valid_a, rx_data_a);
    end
    ack_a();
    send_frame(1'b0, 8'h0F, 1'b1, 1);
    send_bit(1'b0, 1'b1, 6);
    @(negedge clk);
    tests++;
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h0F) begin
      fails++;
      $display("FAIL after_ferr: valid=%b data=%h, want 1/0f", rx_valid_a, rx_data_a);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    int busy0;
    fe0   = fe_b_cnt;
    busy0 = busy_b_cnt;
    send_bit(1'b1, 1'b0, 3);
    send_bit(1'b1, 1'b1, 40);
    @(negedge clk);
    tests++;
    if (busy_b_cnt == busy0 || rx_busy_b !== 1'b0 || rx_valid_b !== 1'b0) begin
      fails++;
      $display("FAIL glitch: busy cycles=%0d busy=%b valid=%b, want >0/0/0",
               busy_b_cnt - busy0, rx_busy_b, rx_valid_b);
    end
    send_frame(1'b1, 8'h81, 1'b1, 16);
    send_bit(1'b1, 1'b1, 20);
    @(negedge clk);
    tests++;
    if (rx_valid_b !== 1'b1 || rx_data_b !== 8'h81 || fe_b_cnt != fe0) begin
      fails++;
      $display("FAIL cpb16_81: valid=%b data=%h ferr=%0d, want 1/81/0", rx_valid_b, rx_data_b,
               fe_b_cnt - fe0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    v = 8'h6B;
    send_bit(1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, v[7-i], 1);
    send_bit(1'b0, v[3], 1);
    @(negedge clk);
    tests++;
    if (rx_busy_a !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: busy=%b, want 1", rx_busy_a);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (rx_valid_a !== 1'b0 || rx_data_a !== 8'h00 || rx_busy_a !== 1'b0 ||
        overrun_a !== 1'b0 || frame_err_a !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b data=%h busy=%b ov=%b fe=%b, want 0/00/0/0/0",
               rx_valid_a, rx_data_a, rx_busy_a, overrun_a, frame_err_a);
    end
    rxd_a = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_valid_a !== 1'b0 || rx_busy_a !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: valid=%b busy=%b, want 0/0", rx_valid_a, rx_busy_a);
    end
    send_frame(1'b0, 8'hE7, 1'b1, 1);
    send_bit(1'b0, 1'b1, 6);
    @(negedge clk);
    tests++;
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'hE7) begin
      fails++;
      $display("FAIL post_reset_frame: valid=%b data=%h, want 1/e7", rx_valid_a, rx_data_a);
    end
  endtask

  initial begin
    reset    = 1'b0;
    rxd_a    = 1'b1;
    rxd_b    = 1'b1;
    rx_ack_a = 1'b0;
    rx_ack_b = 1'b0;
    #19;
    test_reset();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
